// File: rtl/clk_div_sched.sv
// Run-time controller for an even-ratio clock divider. div_out is a registered
// data signal of period 2*active_half; ratio and start/stop change only at period boundaries.
module clk_div_sched #(
  parameter int          CNT_W        = 8,
  parameter int unsigned DEFAULT_HALF = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             div_out,
  output logic             div_rise,
  output logic [CNT_W-1:0] active_half
);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_HALF  = CNT_W'(DEFAULT_HALF);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] active_half_reg;
  logic [CNT_W-1:0] pend_half_reg;
  logic             pend_valid_reg;
  logic             div_out_reg, div_out_next;
  logic             div_rise_reg, div_rise_next;
  logic             cfg_err_reg;

  logic             phase_last;
  logic             apply_pend;
  logic             cfg_accept;

  // Phase length is always taken from the half latched at the last boundary.
  assign phase_last = (cnt_reg == (active_half_reg - ONE));
  assign cfg_accept = cfg_valid && !pend_valid_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_STOP;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_STOP: if (en)         state_next = ST_HI;
      ST_HI:   if (phase_last) state_next = ST_LO;
      ST_LO:   if (phase_last) state_next = en ? ST_HI : ST_STOP;
      default:                 state_next = ST_STOP;
    endcase
  end

  always_comb begin
    div_out_next  = (state_next == ST_HI);
    div_rise_next = (state_next == ST_HI) && (state_reg != ST_HI);
    // Stopping also consumes the pending half so the next start uses it.
    apply_pend    = pend_valid_reg &&
                    (div_rise_next || (state_reg == ST_LO && state_next == ST_STOP));
    if (state_reg == ST_STOP || phase_last) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg         <= '0;
      active_half_reg <= RST_HALF;
      pend_half_reg   <= '0;
      pend_valid_reg  <= 1'b0;
      div_out_reg     <= 1'b0;
      div_rise_reg    <= 1'b0;
      cfg_err_reg     <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      div_out_reg  <= div_out_next;
      div_rise_reg <= div_rise_next;
      cfg_err_reg  <= cfg_accept && (cfg_half == '0);
      if (apply_pend) begin
        active_half_reg <= pend_half_reg;
        pend_valid_reg  <= 1'b0;
      end else if (cfg_accept && (cfg_half != '0)) begin
        pend_half_reg  <= cfg_half;
        pend_valid_reg <= 1'b1;
      end
    end
  end

  assign cfg_ready   = !pend_valid_reg;
  assign cfg_err     = cfg_err_reg;
  assign div_out     = div_out_reg;
  assign div_rise    = div_rise_reg;
  assign active_half = active_half_reg;

endmodule

// File: tb/tb_clk_div_sched.sv
// Directed bench for clk_div_sched: each task drives one scenario and checks
// registered outputs 1 time unit after the rising edge.
module tb_clk_div_sched;

  localparam int CNT_W = 8;

  logic             clk;
  logic             reset;
  logic             en;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_half;
  logic             cfg_ready;
  logic             cfg_err;
  logic             div_out;
  logic             div_rise;
  logic [CNT_W-1:0] active_half;

  int checks = 0;
  int errors = 0;

  clk_div_sched #(.CNT_W(CNT_W), .DEFAULT_HALF(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .cfg_valid   (cfg_valid),
    .cfg_half    (cfg_half),
    .cfg_ready   (cfg_ready),
    .cfg_err     (cfg_err),
    .div_out     (div_out),
    .div_rise    (div_rise),
    .active_half (active_half)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_half = '0;
    step(); step();
    checks++; if (div_out !== 1'b0) begin errors++; $display("FAIL reset_div_out got %0b exp 0", div_out); end
    checks++; if (div_rise !== 1'b0) begin errors++; $display("FAIL reset_div_rise got %0b exp 0", div_rise); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got %0b exp 0", cfg_err); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got %0b exp 1", cfg_ready); end
    checks++; if (active_half !== 8'd1) begin errors++; $display("FAIL reset_active_half got %0d exp 1", active_half); end
    reset = 1'b0;
    step();
    checks++; if (div_out !== 1'b0) begin errors++; $display("FAIL idle_div_out got %0b exp 0", div_out); end
    $display("reset: div_out=%0b active_half=%0d cfg_ready=%0b", div_out, active_half, cfg_ready);
  endtask

  task automatic test_default_div();
    int exp_do[6] = '{1, 0, 1, 0, 1, 0};
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (div_out !== exp_do[i][0]) begin errors++; $display("FAIL div2_out[%0d] got %0b exp %0d", i, div_out, exp_do[i]); end
      checks++; if (div_rise !== exp_do[i][0]) begin errors++; $display("FAIL div2_rise[%0d] got %0b exp %0d", i, div_rise, exp_do[i]); end
      checks++; if (active_half !== 8'd1) begin errors++; $display("FAIL div2_half[%0d] got %0d exp 1", i, active_half); end
    end
    $display("default_div: 6 cycles of divide-by-2 checked");
  endtask

  task automatic test_cfg_apply();
    int exp_do[6] = '{1, 1, 0, 0, 0, 1};
    int exp_rs[6] = '{0, 0, 0, 0, 0, 1};
    step();
    checks++; if (div_out !== 1'b1) begin errors++; $display("FAIL apply_hi got %0b exp 1", div_out); end
    cfg_valid = 1'b1; cfg_half = 8'd3;
    step();
    cfg_valid = 1'b0;
    checks++; if (div_out !== 1'b0) begin errors++; $display("FAIL apply_lo got %0b exp 0", div_out); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL apply_ready_full got %0b exp 0", cfg_ready); end
    checks++; if (active_half !== 8'd1) begin errors++; $display("FAIL apply_half_old got %0d exp 1", active_half); end
    step();
    checks++; if (div_out !== 1'b1 || div_rise !== 1'b1) begin errors++; $display("FAIL apply_boundary got out=%0b rise=%0b exp 1 1", div_out, div_rise); end
    checks++; if (active_half !== 8'd3) begin errors++; $display("FAIL apply_half_new got %0d exp 3", active_half); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL apply_ready_free got %0b exp 1", cfg_ready); end
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (div_out !== exp_do[i][0] || div_rise !== exp_rs[i][0]) begin
        errors++; $display("FAIL div6[%0d] got out=%0b rise=%0b exp %0d %0d", i, div_out, div_rise, exp_do[i], exp_rs[i]);
      end
    end
    $display("cfg_apply: half=3 applied at boundary, active_half=%0d", active_half);
  endtask

  task automatic test_back_to_back();
    int exp_do[4] = '{1, 0, 0, 1};
    cfg_valid = 1'b1; cfg_half = 8'd1;
    step();
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL b2b_first_taken got ready=%0b exp 0", cfg_ready); end
    cfg_half = 8'd2;
    step();
    checks++; if (cfg_ready !== 1'b0 || div_out !== 1'b1) begin errors++; $display("FAIL b2b_blocked got ready=%0b out=%0b exp 0 1", cfg_ready, div_out); end
    step(); step(); step();
    checks++; if (div_out !== 1'b0 || active_half !== 8'd3) begin errors++; $display("FAIL b2b_lo got out=%0b half=%0d exp 0 3", div_out, active_half); end
    step();
    checks++; if (active_half !== 8'd1 || div_rise !== 1'b1 || cfg_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_swap got half=%0d rise=%0b ready=%0b exp 1 1 1", active_half, div_rise, cfg_ready);
    end
    step();
    cfg_valid = 1'b0;
    checks++; if (cfg_ready !== 1'b0 || active_half !== 8'd1 || div_out !== 1'b0) begin
      errors++; $display("FAIL b2b_second_taken got ready=%0b half=%0d out=%0b exp 0 1 0", cfg_ready, active_half, div_out);
    end
    step();
    checks++; if (active_half !== 8'd2 || div_rise !== 1'b1) begin errors++; $display("FAIL b2b_second_apply got half=%0d rise=%0b exp 2 1", active_half, div_rise); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (div_out !== exp_do[i][0]) begin errors++; $display("FAIL div4[%0d] got %0b exp %0d", i, div_out, exp_do[i]); end
    end
    $display("back_to_back: second cfg held off then applied, active_half=%0d", active_half);
  endtask

  task automatic test_cfg_zero();
    cfg_valid = 1'b1; cfg_half = 8'd0;
    step();
    cfg_valid = 1'b0;
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL zero_err_pulse got %0b exp 1", cfg_err); end
    checks++; if (cfg_ready !== 1'b1 || active_half !== 8'd2) begin errors++; $display("FAIL zero_nostore got ready=%0b half=%0d exp 1 2", cfg_ready, active_half); end
    step();
    checks++; if (cfg_err !== 1'b0 || cfg_ready !== 1'b1) begin errors++; $display("FAIL zero_err_end got err=%0b ready=%0b exp 0 1", cfg_err, cfg_ready); end
    step(); step();
    checks++; if (div_rise !== 1'b1 || active_half !== 8'd2) begin errors++; $display("FAIL zero_next_period got rise=%0b half=%0d exp 1 2", div_rise, active_half); end
    $display("cfg_zero: error pulse seen, active_half=%0d", active_half);
  endtask

  task automatic test_en_drop();
    int exp_do[6] = '{1, 0, 0, 0, 0, 0};
    cfg_valid = 1'b1; cfg_half = 8'd3;
    step();
    cfg_valid = 1'b0;
    step(); step(); step();
    checks++; if (active_half !== 8'd3 || div_rise !== 1'b1) begin errors++; $display("FAIL drop_setup got half=%0d rise=%0b exp 3 1", active_half, div_rise); end
    step();
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (div_out !== exp_do[i][0] || div_rise !== 1'b0) begin
        errors++; $display("FAIL drop[%0d] got out=%0b rise=%0b exp %0d 0", i, div_out, div_rise, exp_do[i]);
      end
    end
    en = 1'b1;
    step();
    checks++; if (div_out !== 1'b1 || div_rise !== 1'b1) begin errors++; $display("FAIL restart got out=%0b rise=%0b exp 1 1", div_out, div_rise); end
    $display("en_drop: period completed, stopped, restarted");
  endtask

  task automatic test_reset_mid();
    cfg_valid = 1'b1; cfg_half = 8'd2;
    step();
    cfg_valid = 1'b0;
    step(); step();
    checks++; if (div_out !== 1'b0 || cfg_ready !== 1'b0) begin errors++; $display("FAIL rmid_setup got out=%0b ready=%0b exp 0 0", div_out, cfg_ready); end
    reset = 1'b1;
    step();
    checks++; if (div_out !== 1'b0 || div_rise !== 1'b0) begin errors++; $display("FAIL rmid_out got out=%0b rise=%0b exp 0 0", div_out, div_rise); end
    checks++; if (active_half !== 8'd1 || cfg_ready !== 1'b1) begin errors++; $display("FAIL rmid_state got half=%0d ready=%0b exp 1 1", active_half, cfg_ready); end
    reset = 1'b0;
    step();
    checks++; if (div_out !== 1'b1 || div_rise !== 1'b1 || active_half !== 8'd1) begin
      errors++; $display("FAIL rmid_restart got out=%0b rise=%0b half=%0d exp 1 1 1", div_out, div_rise, active_half);
    end
    step();
    checks++; if (div_out !== 1'b0) begin errors++; $display("FAIL rmid_half1 got %0b exp 0", div_out); end
    $display("reset_mid: pending dropped, restarted at default half");
  endtask

  initial begin
    test_reset();
    test_default_div();
    test_cfg_apply();
    test_back_to_back();
    test_cfg_zero();
    test_en_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
